uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 67 ++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: edge-detected UART byte capture into a FIFO with sticky overflow.
// Define RX_FIFO_AF_EN to add a registered almost_full output (count >= AF_THRESH).
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [7:0] rx_data,
  input  logic rx_rdy,
  input  logic rd_en,
  output logic [7:0] rd_data,
  output logic rd_valid,
  output logic empty,
  output logic full,
  output logic [DEPTH_LOG2:0] count,
  output logic overflow,
  input  logic ovf_clr
`ifdef RX_FIFO_AF_EN
  ,
  output logic almost_full
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic rx_rdy_q, wr_stb, rd_acc, wr_acc, drop;
  logic [DEPTH_LOG2:0] count_nxt;
  always_comb begin
    wr_stb = rx_rdy & ~rx_rdy_q;
    rd_acc = rd_en & ~empty;
    wr_acc = wr_stb & (~full | rd_acc);
    drop = wr_stb & full & ~rd_acc;
    count_nxt = count + (DEPTH_LOG2+1)'(wr_acc) - (DEPTH_LOG2+1)'(rd_acc);
  end
  always_ff @(posedge clk)
    if (wr_acc) mem[wptr] <= rx_data;
  // rx_rdy_q resets high so a level already high at release is not a new byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_rdy_q <= 1'b1;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      rd_data <= 8'h00;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_rdy_q <= rx_rdy;
      wptr <= wptr + DEPTH_LOG2'(wr_acc);
      rptr <= rptr + DEPTH_LOG2'(rd_acc);
      count <= count_nxt;
      empty <= count_nxt == '0;
      full <= count_nxt == (DEPTH_LOG2+1)'(DEPTH);
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rptr];
      overflow <= drop | (overflow & ~ovf_clr);
    end
`ifdef RX_FIFO_AF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) almost_full <= 1'b0;
    else almost_full <= count_nxt >= (DEPTH_LOG2+1)'(AF_THRESH);
`endif
endmodule
